pipelined_select_adder: RTL and testbench
=========================================

Name: pipelined_select_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor. Next generation of the team's fixed 32-bit carry-select adder.
- Uniform select blocks of BLK bits; the carry chain is cut into STAGES register segments.
- Adds valid/ready handshake, subtract mode and a signed-overflow flag.
- Sits between operand-fetch and accumulate logic in the convolution datapath. Sustains one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- BLK, 8, bits per carry-select block. WIDTH % BLK must be 0.
- STAGES, 2, pipeline segments (≥1). NBLK = WIDTH/BLK; NBLK % STAGES must be 0. Violation is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in. Ignored when in_sub=1.
- in_sub  in  1  1 = A−B, 0 = A+B+cin.
- in_sat  in  1  saturate request. Only honoured with SAT_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_s  out  WIDTH  sum/difference.
- out_cout  out  1  carry out of MSB. For subtract, 1 = no borrow.
- out_ovf  out  1  signed overflow, two's complement.

Behaviour:
- Reset (async assert, sync release): all valid bits, out_valid, out_s, out_cout and out_ovf go to 0 immediately. In-flight operations are discarded.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational). Transfer on in_valid && in_ready.
- Latency: exactly STAGES cycles from accept edge to out_valid high. Throughput: 1 op/cycle while out_ready=1.
- Stall: when adv=0, every pipeline register, including valid bits and out_*, holds. Output stays stable until taken.
- Bubbles: an accept cycle with in_valid=0 injects valid=0. Bubbles propagate and are not collapsed.
- Operand conditioning at the input register: b_eff = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
- Segment k (0..STAGES−1):
  - Handles blocks k·NBLK/STAGES .. (k+1)·NBLK/STAGES−1.
  - Each block computes sum0/cout0 (carry-in 0) and sum1/cout1 (carry-in 1), then muxes on the incoming carry.
  - The segment carry-out and the result bits so far are registered with the valid bit.
  - Unprocessed operand bits travel alongside in the pipeline.
- out_cout = carry out of bit WIDTH−1.
- out_ovf = (a[W−1] == b_eff[W−1]) && (s[W−1] != a[W−1]).
- Width rule: no width growth. The result wraps modulo 2^WIDTH. out_cout and out_ovf carry the extra information.
- Order preserved; no duplication or loss under any out_ready pattern.
- in_* values are sampled only on a transfer. Changes at any other time are ignored.

Optional Feature:
- Macro: PSA_SAT_EN.
- Defined: in_sat is registered with the operands. On the final stage, if in_sat && ovf, out_s = a[W−1] ? 1 followed by W−1 zeros (min negative) : 0 followed by W−1 ones (max positive).
  - out_ovf still reports 1. out_cout is unchanged.
  - The clamp mux adds no latency.
- Undefined: in_sat is unconnected internally; no saturation logic is generated.

Test Plan:
- WIDTH=32, BLK=8, STAGES=2, out_ready=1; A=0xFFFFFFFF, B=0x1, cin=0, add → out_s=0x00000000, out_cout=1, out_ovf=0, out_valid exactly 2 cycles after accept.
- Sub A=5, B=7 → out_s=0xFFFFFFFE, out_cout=0, out_ovf=0. Sub A=0x80000000, B=1 → out_s=0x7FFFFFFF, out_ovf=1, out_cout=1.
- Carry across segment boundary: A=0x0000FFFF, B=0x1 → 0x00010000. 100 random back-to-back ops → one result per cycle, all match the reference model.
- Backpressure: stream 6 ops, hold out_ready=0 for 4 cycles mid-stream → in_ready=0 during the stall, out_s held stable, all 6 results in order, none dropped or duplicated.
- Reset mid-flight: drop rst_n with 2 ops in the pipe → out_valid=0 without a clock edge. After release with in_valid=0, no result appears for ≥5 cycles.
- With PSA_SAT_EN: A=0x7FFFFFFF, B=1, in_sat=1 → out_s=0x7FFFFFFF, out_ovf=1. Same op with in_sat=0 → 0x80000000. Without the macro, in_sat=1 → 0x80000000.

Source files
------------

// File: rtl/psa_if.sv
// Operand/result handshake bundle for pipelined_select_adder.
// master = operand producer and result consumer, slave = the adder.
interface psa_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, in_sat, out_ready,
        input  in_ready, out_valid, out_s, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, in_sat, out_ready,
        output in_ready, out_valid, out_s, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder/subtractor: input register plus STAGES carry segments.
// Optional saturation on signed overflow is enabled with the PSA_SAT_EN macro.
module pipelined_select_adder #(
    parameter int WIDTH  = 32,
    parameter int BLK    = 8,
    parameter int STAGES = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    psa_if.slave   bus
);
    localparam int NBLK = WIDTH / BLK;
    localparam int BPS  = (STAGES > 0) ? NBLK / STAGES : 1;
    localparam logic [BLK:0] ONE = (BLK+1)'(1);

    if (WIDTH % BLK != 0) begin : g_chk_blk
        $error("pipelined_select_adder: WIDTH must be a multiple of BLK");
    end
    if (STAGES < 1) begin : g_chk_stages_min
        $error("pipelined_select_adder: STAGES must be at least 1");
    end else if (NBLK % STAGES != 0) begin : g_chk_stages
        $error("pipelined_select_adder: WIDTH/BLK must be a multiple of STAGES");
    end

    // Index k holds the operands about to be processed by segment k.
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0]            vld_q, vld_d;

    logic [STAGES-1:0][WIDTH-1:0] seg_s;
    logic [STAGES-1:0]            seg_c;
    logic [BLK:0]                 blk0, blk1;
    logic                         carry;
    logic                         ovf;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_s_q, out_s_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;
    logic             adv;

`ifdef PSA_SAT_EN
    logic [STAGES-1:0] sat_q, sat_d;

    function automatic logic [WIDTH-1:0] sat_clamp(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`else
    logic unused_sat;
    assign unused_sat = bus.in_sat;
`endif

    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = out_s_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        c_d         = c_q;
        vld_d       = vld_q;
        seg_s       = s_q;
        seg_c       = '0;
        blk0        = '0;
        blk1        = '0;
        carry       = 1'b0;
        ovf         = 1'b0;
        out_valid_d = out_valid_q;
        out_s_d     = out_s_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
`ifdef PSA_SAT_EN
        sat_d       = sat_q;
        sat_d[0]    = bus.in_sat;
`endif

        // Input register: subtract becomes A + ~B + 1.
        a_d[0]   = bus.in_a;
        b_d[0]   = bus.in_sub ? ~bus.in_b : bus.in_b;
        c_d[0]   = bus.in_sub | bus.in_cin;
        s_d[0]   = '0;
        vld_d[0] = bus.in_valid;

        for (int k = 0; k < STAGES; k++) begin
            carry = c_q[k];
            for (int j = 0; j < BPS; j++) begin
                blk0  = {1'b0, a_q[k][(k*BPS+j)*BLK +: BLK]} + {1'b0, b_q[k][(k*BPS+j)*BLK +: BLK]};
                blk1  = blk0 + ONE;
                seg_s[k][(k*BPS+j)*BLK +: BLK] = carry ? blk1[BLK-1:0] : blk0[BLK-1:0];
                carry = carry ? blk1[BLK] : blk0[BLK];
            end
            seg_c[k] = carry;
        end

        // Segment boundaries: partial sum, carry and untouched operand bits advance together.
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            s_d[k]   = seg_s[k-1];
            c_d[k]   = seg_c[k-1];
            vld_d[k] = vld_q[k-1];
`ifdef PSA_SAT_EN
            sat_d[k] = sat_q[k-1];
`endif
        end

        // Output register.
        ovf = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
              (seg_s[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
        out_valid_d = vld_q[STAGES-1];
        out_s_d     = seg_s[STAGES-1];
        out_cout_d  = seg_c[STAGES-1];
        out_ovf_d   = ovf;
`ifdef PSA_SAT_EN
        if (sat_q[STAGES-1] && ovf) begin
            out_s_d = sat_clamp(a_q[STAGES-1][WIDTH-1]);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_s_q     <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (adv) begin
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Operand/partial-sum path: qualified by vld_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (adv) begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
`ifdef PSA_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end
endmodule

// File: tb/tb_pipelined_select_adder.sv
// Self-checking bench for pipelined_select_adder (WIDTH=32, BLK=8, STAGES=2).
// Reference results come from plain integer arithmetic on every accepted operation.
module tb_pipelined_select_adder;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    exp_t q[$];

    psa_if #(.WIDTH(W)) bus ();

    pipelined_select_adder #(.WIDTH(W), .BLK(8), .STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic sat);
        exp_t        r;
        longint      sa, sb, t;
        logic [W:0]  wide;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            t   = sa - sb;
            r.s = a - b;
            r.c = (a >= b);
        end else begin
            t    = sa + sb + longint'(cin);
            wide = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            r.s  = wide[W-1:0];
            r.c  = wide[W];
        end
        r.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
`ifdef PSA_SAT_EN
        if (sat && r.o) r.s = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
        if (sat) r.s = r.s;
`endif
        return r;
    endfunction

    // Scoreboard: every valid output cycle is checked against the oldest pending result.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_result: got out_valid=1 s=0x%0h required no pending result", bus.out_s);
                end else begin
                    chk("sb_s", bus.out_s, q[0].s);
                    chk("sb_cout", bus.out_cout, q[0].c);
                    chk("sb_ovf", bus.out_ovf, q[0].o);
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub, bus.in_sat));
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic sat);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        bus.in_sat   = sat;
    endtask

    task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input logic sat,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        int cyc;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive(a, b, cin, sub, sat);
        #1;
        chk({nm, "_in_ready"}, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_latency"}, cyc, 2);
        chk({nm, "_s"}, bus.out_s, es);
        chk({nm, "_cout"}, bus.out_cout, ec);
        chk({nm, "_ovf"}, bus.out_ovf, eo);
    endtask

    logic [W-1:0] bp_a [6] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_0005, 32'h7FFF_FFFF, 32'h1234_5678, 32'h8000_0000};
    logic [W-1:0] bp_b [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h1111_1111, 32'h0000_0001};
    logic         bp_s [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int n0;
        int idx;
        logic acc;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.in_sat    = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_s", bus.out_s, 32'h0);
        chk("reset_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;

        run_one("wrap_add", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("sub_neg", 32'h5, 32'h7, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_one("seg_carry", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        run_one("sub_cin_ign", 32'h7, 32'h5, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
        run_one("cin_ovf", 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("nosat_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`ifdef PSA_SAT_EN
        run_one("sat_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_one("sat_neg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
        run_one("sat_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
        run_one("sat_ignored", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        run_one("sat_ign_neg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

        // 100 random back-to-back operations, one result per cycle.
        @(posedge clk); #1;
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            #1;
            chk("rand_in_ready", bus.in_ready, 1'b1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rand_count", n_out - n0, 100);

        // Backpressure: out_ready low for 4 cycles in the middle of a 6-op stream.
        @(posedge clk); #1;
        n0  = n_out;
        idx = 0;
        acc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (acc) idx++;
            bus.out_ready = !(c >= 4 && c < 8);
            if (idx < 6) drive(bp_a[idx], bp_b[idx], 1'b0, bp_s[idx], 1'b0);
            else bus.in_valid = 1'b0;
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_count", n_out - n0, 6);
        chk("bp_pending", q.size(), 0);

        // Reset with two operations in flight.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        chk("pre_rst_s", bus.out_s, 32'h2345_6789);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", bus.out_valid, 1'b0);
        chk("rst_async_s", bus.out_s, 32'h0);
        chk("rst_async_cout", bus.out_cout, 1'b0);
        chk("rst_async_ovf", bus.out_ovf, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", bus.out_valid, 1'b0);
        end

        // Pipeline still works after reset.
        run_one("after_rst", 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'h0000_0101, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_pending", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion required finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
